// File: rtl/console_pkg.sv
// Shared definitions for the console receive path.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package console_pkg;

  // Bits per character on the serial line (8N1).
  localparam int unsigned FRAME_BITS = 8;

  // Width of the data-bit index inside a frame.
  localparam int unsigned BIT_IDX_W = $clog2(FRAME_BITS);

  // Index of the final data bit, after which the stop bit is sampled.
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);

  // Smallest usable clocks-per-bit; a half-bit offset needs at least 2.
  localparam logic [31:0] MIN_DIV = 32'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clamp a raw divider register value to the usable range.
  function automatic logic [31:0] eff_div(input logic [31:0] raw);
    return (raw < MIN_DIV) ? MIN_DIV : raw;
  endfunction

endpackage

// File: rtl/console_rx_fifo.sv
// Receive byte storage: holding register (DEPTH=1) or power-of-two circular FIFO.
// Latency: a pushed byte is at the head the cycle after the push edge; head is combinational.
// Backpressure: none; a push into full storage without a same-cycle pop is dropped and flagged.
module console_rx_fifo
  import console_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [FRAME_BITS-1:0] push_dat,
  input  logic                  pop,
  output logic [FRAME_BITS-1:0] head_dat,
  output logic                  head_vld,
  output logic                  drop
);

  if (DEPTH == 1) begin : g_hold
    logic [FRAME_BITS-1:0] hold_q;
    logic                  hold_vld;

    // Single holding register; a push with a pop replaces the byte in place.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        hold_q   <= '0;
        hold_vld <= 1'b0;
      end else if (push && (!hold_vld || pop)) begin
        hold_q   <= push_dat;
        hold_vld <= 1'b1;
      end else if (pop) begin
        hold_vld <= 1'b0;
      end
    end

    assign head_dat = hold_q;
    assign head_vld = hold_vld;
    assign drop     = push && hold_vld && !pop;
  end else begin : g_ring
    localparam int AW = $clog2(DEPTH);

    logic [FRAME_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  do_pop;
    logic                  do_push;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A pop on the same edge frees the slot the push needs, even when full.
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    assign head_dat = mem[rd_ptr];
    assign head_vld = (count != '0);
    assign drop     = push && full && !do_pop;
  end

endmodule

// File: rtl/console_rx.sv
// Console UART receiver (8N1, LSB first) with programmable clocks-per-bit divider.
// Latency: byte visible on reg_dat_do one cycle after the stop-bit sample (2-flop input sync ahead).
// Backpressure: none on the line; full storage drops new bytes and sets sticky rx_overrun.
// Build option: define CONSOLE_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO instead of one holding register.
module console_rx
  import console_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIV = 32'd1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_re,
  output logic [31:0] reg_dat_do,
  output logic        rx_valid,
  output logic        rx_overrun,
  output logic        rx_frame_err,
  input  logic        err_clr
);

`ifdef CONSOLE_RX_FIFO_EN
  localparam int STORE_DEPTH = FIFO_DEPTH;
`else
  // Single holding register; the FIFO depth has no meaning in this build.
  localparam int STORE_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

  logic                  rx_sync1;
  logic                  rx_sync2;
  logic                  rx_prev;
  rx_state_t             state;
  rx_state_t             next_state;
  logic [31:0]           div_reg;
  logic [31:0]           div_shadow;
  logic [31:0]           bit_cnt;
  logic [BIT_IDX_W-1:0]  bit_idx;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  wait_high;
  logic                  bit_tick;
  logic                  start_det;
  logic                  push_byte;
  logic                  ferr_set;
  logic [FRAME_BITS-1:0] fifo_head;
  logic                  fifo_vld;
  logic                  fifo_drop;
  logic                  overrun_q;
  logic                  frame_err_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= ser_rx;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  // Divider register with per-byte write enables.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_reg <= DEFAULT_DIV;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_div_we[i]) div_reg[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
    end
  end

  assign reg_div_do = div_reg;

  // A sample point is reached on the cycle the bit counter has run down to 1.
  assign bit_tick = (bit_cnt <= 32'd1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // FSM next-state and per-cycle event decode.
  always_comb begin
    next_state = state;
    start_det  = 1'b0;
    push_byte  = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!wait_high && rx_prev && !rx_sync2) begin
          next_state = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        // High at mid-start means the low was a glitch, not a frame.
        if (bit_tick) next_state = rx_sync2 ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick && (bit_idx == LAST_BIT)) next_state = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          next_state = IDLE;
          if (rx_sync2) push_byte = 1'b1;
          else          ferr_set  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Bit timing, data shift and break lockout; divider is frozen per frame in div_shadow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_shadow <= MIN_DIV;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      wait_high  <= 1'b0;
    end else begin
      if (start_det) begin
        div_shadow <= eff_div(div_reg);
        bit_cnt    <= eff_div(div_reg) >> 1;
        bit_idx    <= '0;
      end else if (state != IDLE) begin
        bit_cnt <= bit_tick ? div_shadow : (bit_cnt - 32'd1);
      end
      if ((state == DATA) && bit_tick) begin
        shift_q <= {rx_sync2, shift_q[FRAME_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      // After a low stop bit, ignore the line until it returns high.
      if (ferr_set)                         wait_high <= 1'b1;
      else if ((state == IDLE) && rx_sync2) wait_high <= 1'b0;
    end
  end

  console_rx_fifo #(
    .DEPTH(STORE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push_byte),
    .push_dat(shift_q),
    .pop     (reg_dat_re),
    .head_dat(fifo_head),
    .head_vld(fifo_vld),
    .drop    (fifo_drop)
  );

  // Sticky error flags; a set event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= fifo_drop | (overrun_q & ~err_clr);
      frame_err_q <= ferr_set  | (frame_err_q & ~err_clr);
    end
  end

  assign rx_valid     = fifo_vld;
  assign reg_dat_do   = fifo_vld ? {{(32-FRAME_BITS){1'b0}}, fifo_head} : 32'h0;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_console_rx.sv
// Directed bench for console_rx: table of single frames plus hand-written corner sequences.
// Latency: expected stop sample lands 3 + e/2 + 9*e cycles after the line's start edge (e = clamped divider).
// Backpressure: exercises overrun and pop-on-push with storage full.
module tb_console_rx;

`ifdef CONSOLE_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        ser_rx;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_re;
  logic [31:0] reg_dat_do;
  logic        rx_valid;
  logic        rx_overrun;
  logic        rx_frame_err;
  logic        err_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  console_rx #(
    .DEFAULT_DIV(32'd1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ser_rx      (ser_rx),
    .reg_div_we  (reg_div_we),
    .reg_div_di  (reg_div_di),
    .reg_div_do  (reg_div_do),
    .reg_dat_re  (reg_dat_re),
    .reg_dat_do  (reg_dat_do),
    .rx_valid    (rx_valid),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err),
    .err_clr     (err_clr)
  );

  typedef struct {
    logic [7:0]  b;
    int          div;
    bit          stop_hi;
    logic        exp_vld;
    logic [31:0] exp_dat;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int stop_idx(input int e);
    return 3 + e / 2 + 9 * e;
  endfunction

  task automatic write_div(input logic [3:0] we, input logic [31:0] v);
    reg_div_we = we;
    reg_div_di = v;
    @(negedge clk);
    reg_div_we = 4'h0;
  endtask

  task automatic pop_one();
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Drives one full 10-bit frame at e cycles per bit, starting at a negedge (index 0).
  // Optional one-cycle pulses at given negedge indices; rise_k is the first index rx_valid is seen rising.
  task automatic frame(input logic [7:0] b, input int e, input bit stop_hi,
                       input int pop_at, input int clr_at, input int wr_at,
                       input logic [31:0] wr_val, output int rise_k);
    logic [9:0] bits;
    bit was_vld;
    bits   = {stop_hi, b, 1'b0};
    rise_k = -1;
    was_vld = rx_valid;
    for (int k = 0; k < 10 * e; k++) begin
      if (rise_k < 0 && rx_valid && !was_vld) rise_k = k;
      was_vld    = rx_valid;
      ser_rx     = bits[k / e];
      reg_dat_re = (k == pop_at);
      err_clr    = (k == clr_at);
      if (k == wr_at) begin
        reg_div_we = 4'hF;
        reg_div_di = wr_val;
      end else begin
        reg_div_we = 4'h0;
      end
      @(negedge clk);
    end
    ser_rx     = 1'b1;
    reg_dat_re = 1'b0;
    err_clr    = 1'b0;
    reg_div_we = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int rk;
    int e;

    vecs[0] = '{8'h55, 16, 1'b1, 1'b1, 32'h0000_0055, 1'b0};
    vecs[1] = '{8'hA5, 16, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{8'h00,  8, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
    vecs[3] = '{8'hFF,  4, 1'b1, 1'b1, 32'h0000_00FF, 1'b0};
    vecs[4] = '{8'h96,  1, 1'b1, 1'b1, 32'h0000_0096, 1'b0};
    vecs[5] = '{8'h3C,  2, 1'b1, 1'b1, 32'h0000_003C, 1'b0};
    vecs[6] = '{8'h01,  3, 1'b1, 1'b1, 32'h0000_0001, 1'b0};
    vecs[7] = '{8'h80,  5, 1'b0, 1'b0, 32'h0000_0000, 1'b1};

    resetn     = 1'b0;
    ser_rx     = 1'b1;
    reg_div_we = 4'h0;
    reg_div_di = 32'h0;
    reg_dat_re = 1'b0;
    err_clr    = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state.
    check("rst_div", reg_div_do, 32'd1);
    check("rst_vld", rx_valid, 1'b0);
    check("rst_dat", reg_dat_do, 32'h0);
    check("rst_ovr", rx_overrun, 1'b0);
    check("rst_ferr", rx_frame_err, 1'b0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) begin
      e = (vecs[i].div < 2) ? 2 : vecs[i].div;
      write_div(4'hF, 32'(vecs[i].div));
      check($sformatf("v%0d_div", i), reg_div_do, 32'(vecs[i].div));
      frame(vecs[i].b, e, vecs[i].stop_hi, -1, -1, -1, 32'h0, rk);
      check($sformatf("v%0d_vld", i), rx_valid, vecs[i].exp_vld);
      check($sformatf("v%0d_dat", i), reg_dat_do, vecs[i].exp_dat);
      check($sformatf("v%0d_ferr", i), rx_frame_err, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr", i), rx_overrun, 1'b0);
      pop_one();
      clr_err();
      check($sformatf("v%0d_vld_after", i), rx_valid, 1'b0);
      check($sformatf("v%0d_dat_after", i), reg_dat_do, 32'h0);
      check($sformatf("v%0d_ferr_after", i), rx_frame_err, 1'b0);
    end

    // First-byte latency at div=16: stop sample at index 155, valid seen at that negedge.
    write_div(4'hF, 32'd16);
    frame(8'h55, 16, 1'b1, -1, -1, -1, 32'h0, rk);
    check("lat_rise", 32'(rk), 32'(stop_idx(16)));
    check("lat_dat", reg_dat_do, 32'h55);
    pop_one();
    check("lat_pop_vld", rx_valid, 1'b0);
    check("lat_pop_dat", reg_dat_do, 32'h0);

    // Empty pop has no effect.
    pop_one();
    check("empty_pop_vld", rx_valid, 1'b0);
    check("empty_pop_ovr", rx_overrun, 1'b0);

    // 4-cycle glitch: nothing recorded, receiver still ready for a real frame.
    ser_rx = 1'b0;
    repeat (4) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_vld", rx_valid, 1'b0);
    check("glitch_ferr", rx_frame_err, 1'b0);
    check("glitch_ovr", rx_overrun, 1'b0);
    frame(8'h5A, 16, 1'b1, -1, -1, -1, 32'h0, rk);
    check("post_glitch_dat", reg_dat_do, 32'h5A);
    pop_one();

    // err_clr on the very cycle a low stop bit is sampled: flag must end set.
    frame(8'hA5, 16, 1'b0, -1, stop_idx(16) - 1, -1, 32'h0, rk);
    check("clr_race_ferr", rx_frame_err, 1'b1);
    check("clr_race_vld", rx_valid, 1'b0);
    clr_err();
    check("clr_race_after", rx_frame_err, 1'b0);

    // Divider change mid-frame applies only to the next frame.
    frame(8'h3C, 16, 1'b1, -1, -1, 50, 32'd8, rk);
    check("midwr_div", reg_div_do, 32'd8);
    check("midwr_dat", reg_dat_do, 32'h3C);
    pop_one();
    frame(8'hC3, 8, 1'b1, -1, -1, -1, 32'h0, rk);
    check("midwr_next_dat", reg_dat_do, 32'hC3);
    check("midwr_next_ferr", rx_frame_err, 1'b0);
    pop_one();

    // Byte-lane writes to the divider.
    write_div(4'hF, 32'h0000_0010);
    write_div(4'b0010, 32'hAABB_12CC);
    check("lane_b1", reg_div_do, 32'h0000_1210);
    write_div(4'b1001, 32'h7F00_0003);
    check("lane_b30", reg_div_do, 32'h7F00_1203);
    write_div(4'hF, 32'd16);

    // Overrun: DEPTH+1 bytes with no reads; the first DEPTH are kept in order.
    for (int i = 0; i <= DEPTH; i++) begin
      frame(8'(i + 1), 16, 1'b1, -1, -1, -1, 32'h0, rk);
    end
    check("ovr_flag", rx_overrun, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovr_rd%0d", i), reg_dat_do, 32'(i + 1));
      pop_one();
    end
    check("ovr_empty", rx_valid, 1'b0);
    clr_err();
    check("ovr_clr", rx_overrun, 1'b0);

    // Full storage with a pop on the exact push cycle: no overrun, order kept.
    for (int i = 0; i < DEPTH; i++) begin
      frame(8'(8'h10 + i), 16, 1'b1, -1, -1, -1, 32'h0, rk);
    end
    frame(8'h20, 16, 1'b1, stop_idx(16) - 1, -1, -1, 32'h0, rk);
    check("pp_ovr", rx_overrun, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("pp_rd%0d", i), reg_dat_do, 32'(8'h10 + i));
      pop_one();
    end
    check("pp_rd_new", reg_dat_do, 32'h20);
    pop_one();
    check("pp_empty", rx_valid, 1'b0);

    // Reset mid-frame: partial byte abandoned, divider back to default.
    ser_rx = 1'b0;
    repeat (40) @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    ser_rx = 1'b1;
    resetn = 1'b1;
    repeat (200) @(negedge clk);
    check("rstmid_vld", rx_valid, 1'b0);
    check("rstmid_ferr", rx_frame_err, 1'b0);
    check("rstmid_div", reg_div_do, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/console_rx.md
CONSOLE_RX -- requirements
Module: console_rx

Interface
REQ-001 Parameters SHALL be: DEFAULT_DIV, 1, divider value after reset; FIFO_DEPTH, 4, receive entries (power of two) when CONSOLE_RX_FIFO_EN is defined.
REQ-002 clk  in  1  single system clock; all logic is on its rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 ser_rx  in  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-005 reg_div_we  in  4  per-byte write enables for the divider register.
REQ-006 reg_div_di  in  32  divider write data.
REQ-007 reg_div_do  out  32  current divider register value.
REQ-008 reg_dat_re  in  1  pop strobe for the oldest received byte.
REQ-009 reg_dat_do  out  32  {24'b0, oldest byte} when data is available; 32'h0 when empty.
REQ-010 rx_valid  out  1  high while at least one byte is held.
REQ-011 rx_overrun  out  1  sticky; a complete byte was dropped because storage was full.
REQ-012 rx_frame_err  out  1  sticky; a stop bit was sampled low.
REQ-013 err_clr  in  1  one-cycle strobe that clears both sticky flags.

Function
REQ-014 ser_rx SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value, adding 2 cycles of input latency.
REQ-015 Each set bit of reg_div_we SHALL write the matching byte of reg_div_di into the divider register on that clock edge.
REQ-016 An effective divider value below 2 SHALL be treated as 2; reg_div_do SHALL return the raw register value.
REQ-017 The divider SHALL be latched into a frame shadow when a start bit is detected; divider writes during a frame SHALL affect only later frames.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE -> START on a synchronized falling edge; the bit counter is loaded with div/2 (integer division).
REQ-020 At the START sample point, a low line SHALL go to DATA; a high line SHALL be a glitch, return to IDLE, and record nothing.
REQ-021 DATA SHALL sample 8 bits, LSB first, one every div cycles after the start sample, then go to STOP.
REQ-022 STOP SHALL sample div cycles after bit 7; a high line pushes the byte, a low line sets rx_frame_err and discards the byte; both outcomes return to IDLE.
REQ-023 After a low stop bit, IDLE SHALL wait for the line to be high before it arms for a new falling edge (no break retriggering).
REQ-024 A pushed byte SHALL appear on reg_dat_do, with rx_valid high, on the cycle after the stop sample.
REQ-025 reg_dat_do SHALL be combinational from the storage head; reg_dat_re removes the head at the clock edge; reg_dat_re while empty SHALL have no effect.
REQ-026 A push into full storage with no pop in the same cycle SHALL drop the new byte and set rx_overrun; existing contents are unchanged.
REQ-027 A push and a pop in the same cycle SHALL both take effect, with no overrun, including when full.
REQ-028 When err_clr and a new flag-set event occur in the same cycle, the flag SHALL end set.

Reset
REQ-029 While resetn is low: FSM to IDLE, storage empty, rx_valid=0, reg_dat_do=0, rx_overrun=0, rx_frame_err=0, divider=DEFAULT_DIV, synchronizer flops=1.
REQ-030 Reset during a frame SHALL abandon the frame; a partial byte is never pushed.

Configuration
REQ-031 With CONSOLE_RX_FIFO_EN defined, storage SHALL be a FIFO_DEPTH-entry circular FIFO with wrapping read/write pointers and an occupancy count.
REQ-032 Without CONSOLE_RX_FIFO_EN, storage SHALL be a single holding register plus a valid flag; the FIFO_DEPTH parameter is ignored.

Structure
REQ-033 The FSM state encoding, the minimum-divider constant (2) and the frame width (8) SHALL be defined in shared package console_pkg.
REQ-034 Storage SHALL be a sub-module console_rx_fifo, which both configurations instantiate (depth 1 without the macro).

Verification
REQ-035 div=16, send 0x55: rx_valid rises 1 cycle after the stop sample (about 154 cycles after the line edge); reg_dat_do=32'h55; one reg_dat_re pulse returns rx_valid=0 and reg_dat_do=0.
REQ-036 div=16, drive a 4-cycle low pulse on an idle line: no push, no flags set, FSM returns to IDLE.
REQ-037 Send 0xA5 with a low stop bit: rx_frame_err=1, rx_valid=0; an err_clr pulse returns rx_frame_err to 0.
REQ-038 No FIFO, send 0x11 then 0x22 with no reads: reg_dat_do=0x11, rx_overrun=1. With FIFO, send 0x01..0x05: reads return 0x01..0x04, rx_overrun=1.
REQ-039 div=16, write div=8 mid-frame while sending 0x3C: 0x3C is received correctly; the next frame at div=8 receives 0xC3 correctly.
REQ-040 With FIFO full, pulse reg_dat_re on the exact push cycle: no overrun, count stays 4, ordering is preserved.
